// File: rtl/red_xor_seq_if.sv
// Operand/result bus for red_xor_seq: producer side carries operand A,
// consumer side receives the parity bit Z.
interface red_xor_seq_if #(
    parameter int WIDTH = 64
);
    // Both channels use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; valid must not wait for ready, and the
    // receiver may raise ready at any time.
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] A;
    logic             OutValid;
    logic             OutReady;
    logic             Z;
    logic             Busy;

    modport master (
        output InValid,
        output A,
        output OutReady,
        input  InReady,
        input  OutValid,
        input  Z,
        input  Busy
    );

    modport slave (
        input  InValid,
        input  A,
        input  OutReady,
        output InReady,
        output OutValid,
        output Z,
        output Busy
    );
endinterface

// File: rtl/red_xor_seq.sv
// Multi-cycle parity controller: reduces a WIDTH-bit operand to its parity bit
// by XOR-folding CHUNK bits per cycle over WIDTH/CHUNK cycles.
module red_xor_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 8
) (
    input  logic       CLK,
    input  logic       RSTn,
    red_xor_seq_if.slave bus,
    output logic [1:0] dbg_state_o
);
    localparam int NCYC = WIDTH / CHUNK;
    localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

    generate
        if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("red_xor_seq: CHUNK must be in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic             acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             z_q, z_d;
    logic             en_q;

    logic             slice_par;
    logic [WIDTH-1:0] sreg_shift;

    assign slice_par = ^sreg_q[CHUNK-1:0];

    // With a single chunk the whole operand is consumed in one step.
    generate
        if (NCYC == 1) begin : g_shift_one
            assign sreg_shift = '0;
        end else begin : g_shift_many
            assign sreg_shift = {{CHUNK{1'b0}}, sreg_q[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            z_q     <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            en_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE: begin
                if (bus.InValid && en_q) begin
                    sreg_d  = bus.A;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                acc_d  = acc_q ^ slice_par;
                sreg_d = sreg_shift;
                // Counter stops at the final slice so it never wraps.
                if (cnt_q == LAST_CNT) begin
                    z_d     = acc_q ^ slice_par;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.OutReady) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // en_q keeps InReady low until the first edge after reset release.
    assign bus.InReady  = (state_q == S_IDLE) && en_q;
    assign bus.OutValid = (state_q == S_DONE);
    assign bus.Z        = z_q;
    assign bus.Busy     = (state_q != S_IDLE);
    assign dbg_state_o  = state_q;
endmodule

// File: tb/tb_red_xor_seq.sv
// Directed bench for red_xor_seq at CHUNK = 8, 1 and 64 with WIDTH = 64.
module tb_red_xor_seq;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned edge_cnt = 0;
    int n_assert = 0;
    int n_fail = 0;

    logic [1:0] st8, st1, st64;
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    red_xor_seq_if #(.WIDTH(W)) if8 ();
    red_xor_seq_if #(.WIDTH(W)) if1 ();
    red_xor_seq_if #(.WIDTH(W)) if64 ();

    red_xor_seq #(.WIDTH(W), .CHUNK(8)) u_dut8 (
        .CLK(clk), .RSTn(rst_n), .bus(if8), .dbg_state_o(st8)
    );
    red_xor_seq #(.WIDTH(W), .CHUNK(1)) u_dut1 (
        .CLK(clk), .RSTn(rst_n), .bus(if1), .dbg_state_o(st1)
    );
    red_xor_seq #(.WIDTH(W), .CHUNK(64)) u_dut64 (
        .CLK(clk), .RSTn(rst_n), .bus(if64), .dbg_state_o(st64)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ncyc_of(input int sel);
        return (sel == 1) ? 64 : (sel == 64) ? 1 : 8;
    endfunction

    function automatic logic rdy(input int sel);
        case (sel)
            1:       return if1.InReady;
            64:      return if64.InReady;
            default: return if8.InReady;
        endcase
    endfunction

    function automatic logic ovld(input int sel);
        case (sel)
            1:       return if1.OutValid;
            64:      return if64.OutValid;
            default: return if8.OutValid;
        endcase
    endfunction

    function automatic logic zout(input int sel);
        case (sel)
            1:       return if1.Z;
            64:      return if64.Z;
            default: return if8.Z;
        endcase
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [W-1:0] a);
        case (sel)
            1:       begin if1.InValid = v;  if1.A = a;  end
            64:      begin if64.InValid = v; if64.A = a; end
            default: begin if8.InValid = v;  if8.A = a;  end
        endcase
    endtask

    task automatic drive_ordy(input int sel, input logic v);
        case (sel)
            1:       if1.OutReady = v;
            64:      if64.OutReady = v;
            default: if8.OutReady = v;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction: accept, count latency, check result, consume.
    task automatic do_op(input int sel, input logic [W-1:0] a, input logic exp_z, input string tag);
        int  lat;
        bit  seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (rdy(sel)) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_ready"}, 64'(seen), 64'd1);
        drive_in(sel, 1'b1, a);
        tick();
        drive_in(sel, 1'b0, ~a);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            lat++;
            if (ovld(sel)) break;
        end
        check({tag, "_latency"}, 64'(lat), 64'(ncyc_of(sel)));
        check({tag, "_z"}, 64'(zout(sel)), 64'(exp_z));
        drive_ordy(sel, 1'b1);
        tick();
        drive_ordy(sel, 1'b0);
        check({tag, "_idle_ready"}, 64'(rdy(sel)), 64'd1);
        check({tag, "_z_hold"}, 64'(zout(sel)), 64'(exp_z));
    endtask

    logic [W-1:0] dir_a [7];
    logic         dir_z [7];
    logic [W-1:0] b2b_a [4];
    logic         b2b_z [4];
    int unsigned  acc_edge [4];
    int           sweep_sel [3];

    initial begin
        int  acc_idx;
        int  res_idx;
        bit  flag;
        logic [W-1:0] ra;
        logic [0:0]   ez;

        dir_a[0] = 64'h0;                    dir_z[0] = 1'b0;
        dir_a[1] = 64'h1;                    dir_z[1] = 1'b1;
        dir_a[2] = 64'hFFFF_FFFF_FFFF_FFFF;  dir_z[2] = 1'b0;
        dir_a[3] = 64'h8000_0000_0000_0000;  dir_z[3] = 1'b1;
        dir_a[4] = 64'h0123_4567_89AB_CDEF;  dir_z[4] = 1'b0;
        dir_a[5] = 64'h7;                    dir_z[5] = 1'b1;
        dir_a[6] = 64'h0100_0000_0000_0000;  dir_z[6] = 1'b1;

        b2b_a[0] = 64'hA5A5_A5A5_A5A5_A5A5;  b2b_z[0] = 1'b0;
        b2b_a[1] = 64'h1;                    b2b_z[1] = 1'b1;
        b2b_a[2] = 64'hDEAD_BEEF_0000_0000;  b2b_z[2] = 1'b0;
        b2b_a[3] = 64'hF8;                   b2b_z[3] = 1'b1;

        sweep_sel[0] = 1; sweep_sel[1] = 8; sweep_sel[2] = 64;

        // Clock/reset
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            drive_in(sweep_sel[s], 1'b0, '0);
            drive_ordy(sweep_sel[s], 1'b0);
        end
        #12;
        check("rst_inready", 64'(if8.InReady), 64'd0);
        check("rst_outvalid", 64'(if8.OutValid), 64'd0);
        check("rst_z", 64'(if8.Z), 64'd0);
        check("rst_busy", 64'(if8.Busy), 64'd0);
        check("rst_state", 64'(st8), 64'd0);
        check("rst_state_c1", 64'(st1), 64'd0);
        check("rst_state_c64", 64'(st64), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        check("post_rst_inready8", 64'(if8.InReady), 64'd1);
        check("post_rst_inready1", 64'(if1.InReady), 64'd1);
        check("post_rst_inready64", 64'(if64.InReady), 64'd1);

        // Directed operands on CHUNK=8
        for (int i = 0; i < 7; i++) begin
            do_op(8, dir_a[i], dir_z[i], $sformatf("dir%0d", i));
        end

        // Backpressure: result held in DONE, new operand ignored
        do_op(8, 64'h0, 1'b0, "bp_pre");
        drive_in(8, 1'b1, 64'h0000_0000_0000_0100);
        tick();
        drive_in(8, 1'b0, 64'h0);
        flag = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (if8.OutValid) begin
                flag = 1'b1;
                break;
            end
        end
        check("bp_reach_done", 64'(flag), 64'd1);
        drive_in(8, 1'b1, 64'hFFFF_0000_FFFF_0001);
        for (int i = 0; i < 5; i++) begin
            check("bp_outvalid", 64'(if8.OutValid), 64'd1);
            check("bp_z", 64'(if8.Z), 64'd1);
            check("bp_inready", 64'(if8.InReady), 64'd0);
            check("bp_busy", 64'(if8.Busy), 64'd1);
            tick();
        end
        drive_ordy(8, 1'b1);
        tick();
        drive_in(8, 1'b0, 64'h0);
        drive_ordy(8, 1'b0);
        check("bp_release_outvalid", 64'(if8.OutValid), 64'd0);
        check("bp_release_inready", 64'(if8.InReady), 64'd1);
        check("bp_release_busy", 64'(if8.Busy), 64'd0);

        // Reset during the 4th RUN cycle
        drive_in(8, 1'b1, 64'h5);
        tick();
        drive_in(8, 1'b0, 64'h0);
        tick();
        tick();
        tick();
        check("midrun_state", 64'(st8), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_state", 64'(st8), 64'd0);
        check("midrun_rst_outvalid", 64'(if8.OutValid), 64'd0);
        check("midrun_rst_inready", 64'(if8.InReady), 64'd0);
        check("midrun_rst_busy", 64'(if8.Busy), 64'd0);
        #2 rst_n = 1'b1;
        flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (if8.OutValid) flag = 1'b1;
        end
        check("midrun_no_outvalid", 64'(flag), 64'd0);
        do_op(8, 64'h3, 1'b0, "after_rst");

        // Back-to-back with InValid and OutReady held high
        acc_idx = 0;
        res_idx = 0;
        drive_ordy(8, 1'b1);
        drive_in(8, 1'b1, b2b_a[0]);
        for (int c = 0; c < 200 && res_idx < 4; c++) begin
            if (acc_idx == 4) drive_in(8, 1'b0, 64'h0);
            if (if8.InReady && acc_idx < 4) begin
                drive_in(8, 1'b1, b2b_a[acc_idx]);
                exp_q.push_back(b2b_z[acc_idx]);
                acc_edge[acc_idx] = edge_cnt + 1;
                acc_idx++;
            end
            if (if8.OutValid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_unexpected_result", 64'd1, 64'd0);
                end else begin
                    ez = exp_q.pop_front();
                    check($sformatf("b2b_z%0d", res_idx), 64'(if8.Z), 64'(ez));
                end
                res_idx++;
            end
            tick();
        end
        drive_in(8, 1'b0, 64'h0);
        drive_ordy(8, 1'b0);
        check("b2b_results", 64'(res_idx), 64'd4);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("b2b_spacing%0d", i), 64'(acc_edge[i] - acc_edge[i-1]), 64'd10);
        end
        tick();

        // CHUNK sweep: directed corners plus random operands
        for (int s = 0; s < 3; s++) begin
            do_op(sweep_sel[s], 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, $sformatf("sw%0d_ones", sweep_sel[s]));
            do_op(sweep_sel[s], 64'h8000_0000_0000_0000, 1'b1, $sformatf("sw%0d_msb", sweep_sel[s]));
            for (int i = 0; i < 40; i++) begin
                ra = {$urandom, $urandom};
                do_op(sweep_sel[s], ra, ^ra, $sformatf("sw%0d_rnd%0d", sweep_sel[s], i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
